// File: rtl/culsans_region_classifier.sv
// Programmable memory-attribute classifier: NR_RULES-entry region table, 2-stage valid/ready lookup.
// Optional entry locking is enabled by defining CULSANS_REGION_LOCK_EN.
module culsans_region_classifier #(
    parameter int unsigned NR_RULES     = 4,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned ID_WIDTH     = 4,
    parameter logic [2:0]  DEFAULT_ATTR = 3'b000,
    localparam int unsigned IDX_W       = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_we_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_len_i,
    input  logic [2:0]            cfg_attr_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_err_o,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [ID_WIDTH-1:0]   resp_id_o,
    output logic                  resp_hit_o,
    output logic [IDX_W-1:0]      resp_rule_o,
    output logic [2:0]            resp_attr_o
);

    logic [NR_RULES-1:0]   en_reg;
    logic [ADDR_WIDTH-1:0] base_reg [NR_RULES];
    logic [ADDR_WIDTH-1:0] len_reg  [NR_RULES];
    logic [2:0]            attr_reg [NR_RULES];

    logic idx_ok;
    logic wr_blocked;
    logic wr_en;
    logic cfg_err_reg;

    assign idx_ok = (32'(cfg_idx_i) < NR_RULES);

`ifdef CULSANS_REGION_LOCK_EN
    logic [NR_RULES-1:0] lock_reg;
    assign wr_blocked = idx_ok && lock_reg[cfg_idx_i];
`else
    logic unused_lock;
    assign unused_lock = cfg_lock_i;
    assign wr_blocked  = 1'b0;
`endif

    assign wr_en = cfg_we_i && idx_ok && !wr_blocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we_i && (!idx_ok || wr_blocked);
        end
    end
    assign cfg_err_o = cfg_err_reg;

    // Table storage and per-entry range compare against the table as it stands this cycle.
    logic [NR_RULES-1:0] hit_vec;

    for (genvar gi = 0; gi < NR_RULES; gi++) begin : g_entry
        logic [ADDR_WIDTH:0] lo_ext;
        logic [ADDR_WIDTH:0] hi_ext;
        logic [ADDR_WIDTH:0] addr_ext;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                en_reg[gi]   <= 1'b0;
                base_reg[gi] <= '0;
                len_reg[gi]  <= '0;
                attr_reg[gi] <= 3'b000;
            end else if (wr_en && (cfg_idx_i == IDX_W'(gi))) begin
                en_reg[gi]   <= cfg_en_i;
                base_reg[gi] <= cfg_base_i;
                len_reg[gi]  <= cfg_len_i;
                attr_reg[gi] <= cfg_attr_i;
            end
        end

`ifdef CULSANS_REGION_LOCK_EN
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lock_reg[gi] <= 1'b0;
            end else if (wr_en && (cfg_idx_i == IDX_W'(gi))) begin
                lock_reg[gi] <= cfg_lock_i;
            end
        end
`endif

        // One extra bit keeps base+len from wrapping for regions touching the top of memory.
        assign lo_ext   = {1'b0, base_reg[gi]};
        assign hi_ext   = {1'b0, base_reg[gi]} + {1'b0, len_reg[gi]};
        assign addr_ext = {1'b0, req_addr_i};
        assign hit_vec[gi] = en_reg[gi] && (len_reg[gi] != '0) &&
                             (lo_ext <= addr_ext) && (addr_ext < hi_ext);
    end

    // Pipeline handshake.
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv      = !s2_valid_reg || resp_ready_i;
    assign s1_adv      = !s1_valid_reg || s2_adv;
    assign req_ready_o = s1_adv;

    // Stage 1 also snapshots attributes so a later table write cannot alter an in-flight result.
    logic [NR_RULES-1:0] s1_hit_reg;
    logic [ID_WIDTH-1:0] s1_id_reg;
    logic [2:0]          s1_attr_reg [NR_RULES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg <= 1'b0;
            s1_hit_reg   <= '0;
            s1_id_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= req_valid_i;
            if (req_valid_i) begin
                s1_hit_reg <= hit_vec;
                s1_id_reg  <= req_id_i;
            end
        end
    end

    for (genvar gi = 0; gi < NR_RULES; gi++) begin : g_s1_attr
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_attr_reg[gi] <= 3'b000;
            end else if (s1_adv && req_valid_i) begin
                s1_attr_reg[gi] <= attr_reg[gi];
            end
        end
    end

    // Lowest index wins: scan downward so the last assignment is the lowest hit.
    logic             enc_hit;
    logic [IDX_W-1:0] enc_rule;
    logic [2:0]       enc_attr;

    always_comb begin
        enc_hit  = 1'b0;
        enc_rule = '0;
        enc_attr = DEFAULT_ATTR;
        for (int i = NR_RULES - 1; i >= 0; i--) begin
            if (s1_hit_reg[i]) begin
                enc_hit  = 1'b1;
                enc_rule = IDX_W'(i);
                enc_attr = s1_attr_reg[i];
            end
        end
    end

    logic                s2_hit_reg;
    logic [IDX_W-1:0]    s2_rule_reg;
    logic [2:0]          s2_attr_reg;
    logic [ID_WIDTH-1:0] s2_id_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_reg <= 1'b0;
            s2_hit_reg   <= 1'b0;
            s2_rule_reg  <= '0;
            s2_attr_reg  <= DEFAULT_ATTR;
            s2_id_reg    <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_hit_reg  <= enc_hit;
                s2_rule_reg <= enc_rule;
                s2_attr_reg <= enc_attr;
                s2_id_reg   <= s1_id_reg;
            end
        end
    end

    assign resp_valid_o = s2_valid_reg;
    assign resp_hit_o   = s2_hit_reg;
    assign resp_rule_o  = s2_rule_reg;
    assign resp_attr_o  = s2_attr_reg;
    assign resp_id_o    = s2_id_reg;

endmodule

// File: tb/tb_culsans_region_classifier.sv
// Scoreboard bench for culsans_region_classifier; a behavioural table model predicts each lookup.
// Lock checks follow CULSANS_REGION_LOCK_EN when it is defined for the build.
module tb_culsans_region_classifier;

    localparam int unsigned NR   = 4;
    localparam int unsigned AW   = 64;
    localparam int unsigned IW   = 4;
    localparam int unsigned XW   = 2;
    localparam logic [2:0]  DEF  = 3'b000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cfg_we_i;
    logic [XW-1:0] cfg_idx_i;
    logic [AW-1:0] cfg_base_i;
    logic [AW-1:0] cfg_len_i;
    logic [2:0]    cfg_attr_i;
    logic          cfg_en_i;
    logic          cfg_lock_i;
    logic          cfg_err_o;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [IW-1:0] req_id_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [IW-1:0] resp_id_o;
    logic          resp_hit_o;
    logic [XW-1:0] resp_rule_o;
    logic [2:0]    resp_attr_o;

    culsans_region_classifier #(
        .NR_RULES(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEFAULT_ATTR(DEF)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_base_i(cfg_base_i),
        .cfg_len_i(cfg_len_i), .cfg_attr_i(cfg_attr_i), .cfg_en_i(cfg_en_i),
        .cfg_lock_i(cfg_lock_i), .cfg_err_o(cfg_err_o),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_id_i(req_id_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_id_o(resp_id_o), .resp_hit_o(resp_hit_o),
        .resp_rule_o(resp_rule_o), .resp_attr_o(resp_attr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference table model.
    logic          m_en   [NR];
    logic [AW-1:0] m_base [NR];
    logic [AW-1:0] m_len  [NR];
    logic [2:0]    m_attr [NR];
    logic          m_lock [NR];

    typedef struct packed {
        logic [IW-1:0] id;
        logic          hit;
        logic [XW-1:0] rule;
        logic [2:0]    attr;
    } exp_t;

    exp_t sb_q[$];
    logic err_pending;

    function automatic exp_t model_lookup(input logic [AW-1:0] addr, input logic [IW-1:0] id);
        exp_t e;
        e.id = id; e.hit = 1'b0; e.rule = '0; e.attr = DEF;
        for (int i = 0; i < NR; i++) begin
            if (!e.hit && m_en[i] && m_len[i] != 0 && addr >= m_base[i] &&
                ({1'b0, addr} < ({1'b0, m_base[i]} + {1'b0, m_len[i]}))) begin
                e.hit = 1'b1; e.rule = XW'(i); e.attr = m_attr[i];
            end
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_en[i] = 1'b0; m_base[i] = '0; m_len[i] = '0; m_attr[i] = 3'b000; m_lock[i] = 1'b0;
        end
    endtask

    // Monitor: pop on response transfer, push on acceptance (old table), then apply any write.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb_q.delete();
            model_clear();
            err_pending = 1'b0;
        end else begin
            chk("cfg_err", cfg_err_o, err_pending);
            err_pending = 1'b0;
            if (resp_valid_o && resp_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("resp id=%0d hit=%0d rule=%0d attr=%b (exp id=%0d hit=%0d rule=%0d attr=%b)",
                             resp_id_o, resp_hit_o, resp_rule_o, resp_attr_o, e.id, e.hit, e.rule, e.attr);
                    chk("resp_id", resp_id_o, e.id);
                    chk("resp_hit", resp_hit_o, e.hit);
                    chk("resp_rule", resp_rule_o, e.rule);
                    chk("resp_attr", resp_attr_o, e.attr);
                end
            end
            if (req_valid_i && req_ready_o)
                sb_q.push_back(model_lookup(req_addr_i, req_id_i));
            if (cfg_we_i) begin
                logic blocked;
                blocked = 1'b0;
`ifdef CULSANS_REGION_LOCK_EN
                blocked = m_lock[cfg_idx_i];
`endif
                err_pending = blocked;
                if (!blocked) begin
                    m_en[cfg_idx_i]   = cfg_en_i;
                    m_base[cfg_idx_i] = cfg_base_i;
                    m_len[cfg_idx_i]  = cfg_len_i;
                    m_attr[cfg_idx_i] = cfg_attr_i;
                    m_lock[cfg_idx_i] = cfg_lock_i;
                end
            end
        end
    end

    task automatic cfg_wr(input int idx, input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input logic [2:0] attr, input logic en, input logic lock);
        cfg_we_i = 1'b1; cfg_idx_i = XW'(idx); cfg_base_i = base; cfg_len_i = len;
        cfg_attr_i = attr; cfg_en_i = en; cfg_lock_i = lock;
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0; cfg_lock_i = 1'b0;
    endtask

    task automatic lookup(input logic [AW-1:0] addr, input logic [IW-1:0] id);
        logic acc;
        req_valid_i = 1'b1; req_addr_i = addr; req_id_i = id;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = req_ready_o;
            @(posedge clk_i); #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) begin
            @(posedge clk_i); #1;
        end
        chk("drain_left", sb_q.size(), 0);
    endtask

    logic [AW-1:0] bp_addr [4];
    int sent;
    logic acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bp_addr[0] = 64'h8004_0000; bp_addr[1] = 64'hC000_0000;
        bp_addr[2] = 64'h8000_0000; bp_addr[3] = 64'h0000_1000;
        rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_base_i = '0; cfg_len_i = '0;
        cfg_attr_i = 3'b000; cfg_en_i = 1'b0; cfg_lock_i = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; req_id_i = '0; resp_ready_i = 1'b1;
        model_clear();
        err_pending = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_hit", resp_hit_o, 0);
        chk("rst_resp_rule", resp_rule_o, 0);
        chk("rst_resp_attr", resp_attr_o, DEF);
        chk("rst_resp_id", resp_id_o, 0);
        chk("rst_cfg_err", cfg_err_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_req_ready", req_ready_o, 1);

        // Empty table miss with latency check.
        lookup(64'h8000_1000, 4'd3);
        chk("lat_cycle1", resp_valid_o, 0);
        @(posedge clk_i); #1;
        chk("lat_cycle2", resp_valid_o, 1);
        drain();

        cfg_wr(1, 64'h8000_0000, 64'h4000_0000, 3'b011, 1'b1, 1'b0);
        lookup(64'h8004_0000, 4'd4);
        lookup(64'hC000_0000, 4'd5);
        drain();

        cfg_wr(0, 64'h8004_0000, 64'h0004_0000, 3'b010, 1'b1, 1'b0);
        lookup(64'h8004_0010, 4'd6);
        lookup(64'h8008_0000, 4'd7);
        drain();

        // Back-pressure: only two requests fit while the output is stalled.
        resp_ready_i = 1'b0;
        sent = 0;
        req_valid_i = 1'b1; req_addr_i = bp_addr[0]; req_id_i = 4'd8;
        for (int c = 0; c < 6; c++) begin
            acc = req_ready_o;
            @(posedge clk_i); #1;
            if (acc) begin
                sent++;
                req_addr_i = bp_addr[sent % 4]; req_id_i = IW'(8 + sent);
            end
        end
        chk("bp_accepted", sent, 2);
        chk("bp_ready_low", req_ready_o, 0);
        chk("bp_resp_valid", resp_valid_o, 1);
        resp_ready_i = 1'b1;
        for (int c = 0; c < 20 && sent < 4; c++) begin
            acc = req_ready_o;
            @(posedge clk_i); #1;
            if (acc) begin
                sent++;
                req_addr_i = bp_addr[sent % 4]; req_id_i = IW'(8 + sent);
            end
        end
        req_valid_i = 1'b0;
        chk("bp_all_sent", sent, 4);
        drain();

        // Top-of-memory region and zero-length entry.
        cfg_wr(2, 64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_0000_1000, 3'b101, 1'b1, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 4'd1);
        lookup(64'hFFFF_FFFF_FFFF_EFFF, 4'd2);
        cfg_wr(3, 64'h0, 64'h0, 3'b111, 1'b1, 1'b0);
        lookup(64'h0, 4'd3);
        drain();

        // Same-cycle write and lookup on entry 3: old (zero-length) contents apply.
        chk("wl_ready", req_ready_o, 1);
        cfg_we_i = 1'b1; cfg_idx_i = 2'd3; cfg_base_i = 64'h0; cfg_len_i = 64'h100;
        cfg_attr_i = 3'b111; cfg_en_i = 1'b1; cfg_lock_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 64'h10; req_id_i = 4'd9;
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0; req_valid_i = 1'b0;
        lookup(64'h10, 4'd10);
        drain();

        // Locking (a plain rewrite when the feature is absent).
        cfg_wr(0, 64'h8004_0000, 64'h0004_0000, 3'b010, 1'b1, 1'b1);
        cfg_wr(0, 64'h8004_0000, 64'h0004_0000, 3'b111, 1'b1, 1'b0);
`ifdef CULSANS_REGION_LOCK_EN
        chk("lock_err_pulse", cfg_err_o, 1);
`else
        chk("lock_err_pulse", cfg_err_o, 0);
`endif
        @(posedge clk_i); #1;
        chk("lock_err_end", cfg_err_o, 0);
        lookup(64'h8004_0010, 4'd11);
        drain();

        // Reset during a full stall drops in-flight lookups and clears the table.
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 64'h8004_0010; req_id_i = 4'd12;
        repeat (3) @(posedge clk_i);
        #1;
        chk("stall_valid", resp_valid_o, 1);
        rst_ni = 1'b0; req_valid_i = 1'b0;
        #1;
        chk("midrst_resp_valid", resp_valid_o, 0);
        chk("midrst_req_ready", req_ready_o, 1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1; resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_valid", resp_valid_o, 0);
        lookup(64'h8004_0010, 4'd13);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 4'd14);
        drain();
        cfg_wr(0, 64'h8004_0000, 64'h0004_0000, 3'b110, 1'b1, 1'b0);
        lookup(64'h8004_0010, 4'd15);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
